// File: rtl/follow_chk_pkg.sv
// Shared types and helpers for the follow checker: FSM state encoding and latency clamping.
package follow_chk_pkg;

  localparam int MAX_LAT_DEF = 7;

  typedef enum logic [1:0] {IDLE, FILL, CHECK} state_t;

  function automatic int clamp_lat(input int lat, input int max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/follow_chk_if.sv
// Bundle of the observed pair (x, y), checker controls and status outputs.
interface follow_chk_if import follow_chk_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int TOL_W   = 3,
  parameter int CNT_W   = 16
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic             en;
  logic [LAT_W-1:0] lat;
  logic [TOL_W-1:0] tol;
  logic             clr;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             armed;
  logic             mismatch;
  logic             fail;
  logic             fail_sticky;
  logic [CNT_W-1:0] err_cnt;
  logic [WIDTH-1:0] ff_exp;
  logic [WIDTH-1:0] ff_act;
  logic [CNT_W-1:0] ff_cyc;

  modport master (
    output en, lat, tol, clr, x, y,
    input  armed, mismatch, fail, fail_sticky, err_cnt, ff_exp, ff_act, ff_cyc
  );

  modport slave (
    input  en, lat, tol, clr, x, y,
    output armed, mismatch, fail, fail_sticky, err_cnt, ff_exp, ff_act, ff_cyc
  );

endinterface

// File: rtl/follow_chk_dly.sv
// Free-running MAX_LAT-deep shift register of x with a latency-selected tap;
// lat=0 passes x straight through without a register.
module follow_chk_dly import follow_chk_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int LAT_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [LAT_W-1:0] lat,
  output logic [WIDTH-1:0] x_d
);

  logic [WIDTH-1:0] stage [1:MAX_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= MAX_LAT; i++) stage[i] <= '0;
    end else begin
      stage[1] <= x;
      for (int i = 2; i <= MAX_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    x_d = x;
    for (int i = 1; i <= MAX_LAT; i++) begin
      if (int'(lat) == i) x_d = stage[i];
    end
  end

endmodule

// File: rtl/follow_checker.sv
// Checks that y follows x after a selectable latency, forgiving short mismatch runs,
// counting failures and capturing the first one since the last clear.
module follow_checker import follow_chk_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int MAX_LAT = MAX_LAT_DEF,
  parameter int TOL_W   = 3,
  parameter int CNT_W   = 16
) (
  input logic       clk,
  input logic       rst_n,
  follow_chk_if.slave chk
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  state_t           state;
  logic [LAT_W-1:0] lat_c;
  logic [LAT_W-1:0] lat_q;
  logic [LAT_W-1:0] fill_cnt;
  logic [TOL_W:0]   run_cnt;
  logic [TOL_W:0]   tol_p1;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] ff_cyc;
  logic [WIDTH-1:0] x_d;
  logic [WIDTH-1:0] ff_exp;
  logic [WIDTH-1:0] ff_act;
  logic             armed;
  logic             mismatch;
  logic             lat_chg;
  logic             fail_hit;
  logic             rec;
  logic             fail_q;
  logic             sticky;
  logic             ff_valid;

  follow_chk_dly #(
    .WIDTH   (WIDTH),
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (chk.x),
    .lat   (lat_c),
    .x_d   (x_d)
  );

  assign lat_c    = LAT_W'(clamp_lat(int'(chk.lat), MAX_LAT));
  assign tol_p1   = {1'b0, chk.tol} + (TOL_W+1)'(1);
  assign armed    = (state == CHECK);
  assign mismatch = armed && (chk.y != x_d);
  assign lat_chg  = (lat_c != lat_q);
  assign fail_hit = mismatch && (run_cnt == {1'b0, chk.tol});
  // A failure is only recorded if the FSM stays in CHECK, so fail never shows outside CHECK.
  assign rec      = fail_hit && chk.en && !lat_chg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_q    <= '0;
      fill_cnt <= '0;
      run_cnt  <= '0;
      cyc      <= '0;
    end else if (!chk.en) begin
      state   <= IDLE;
      run_cnt <= '0;
      cyc     <= '0;
    end else if (state == IDLE || lat_chg) begin
      lat_q   <= lat_c;
      run_cnt <= '0;
      cyc     <= '0;
      if (lat_c == '0) begin
        state <= CHECK;
      end else begin
        state    <= FILL;
        fill_cnt <= lat_c - LAT_W'(1);
      end
    end else begin
      case (state)
        FILL: begin
          if (fill_cnt == '0) state <= CHECK;
          else fill_cnt <= fill_cnt - LAT_W'(1);
        end
        CHECK: begin
          cyc <= (cyc == '1) ? cyc : cyc + CNT_W'(1);
          if (mismatch) run_cnt <= (run_cnt < tol_p1) ? run_cnt + (TOL_W+1)'(1) : tol_p1;
          else run_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear happens before record, so a failure coinciding with clr becomes the new first failure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_q   <= 1'b0;
      sticky   <= 1'b0;
      ff_valid <= 1'b0;
      err_cnt  <= '0;
      ff_exp   <= '0;
      ff_act   <= '0;
      ff_cyc   <= '0;
    end else begin
      fail_q <= rec;
      if (chk.clr) begin
        err_cnt  <= rec ? CNT_W'(1) : '0;
        sticky   <= rec;
        ff_valid <= rec;
      end else if (rec) begin
        err_cnt  <= (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
        sticky   <= 1'b1;
        ff_valid <= 1'b1;
      end
      if (rec && (chk.clr || !ff_valid)) begin
        ff_exp <= x_d;
        ff_act <= chk.y;
        ff_cyc <= cyc;
      end else if (chk.clr) begin
        ff_exp <= '0;
        ff_act <= '0;
        ff_cyc <= '0;
      end
    end
  end

  assign chk.armed       = armed;
  assign chk.mismatch    = mismatch;
  assign chk.fail        = fail_q;
  assign chk.fail_sticky = sticky;
  assign chk.err_cnt     = err_cnt;
  assign chk.ff_exp      = ff_exp;
  assign chk.ff_act      = ff_act;
  assign chk.ff_cyc      = ff_cyc;

endmodule

// File: tb/tb_follow_checker.sv
// Directed bench for follow_checker: latency fill, tolerance, failure capture, clear and reset.
module tb_follow_checker;
  import follow_chk_pkg::*;

  localparam int WIDTH   = 8;
  localparam int MAX_LAT = 7;
  localparam int TOL_W   = 3;
  localparam int CNT_W   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  follow_chk_if #(.WIDTH(WIDTH), .MAX_LAT(MAX_LAT), .TOL_W(TOL_W), .CNT_W(CNT_W)) bus ();

  follow_checker #(.WIDTH(WIDTH), .MAX_LAT(MAX_LAT), .TOL_W(TOL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .chk   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [2:0] l, input logic [2:0] t,
                               input logic c, input logic [7:0] xv, input logic [7:0] yv);
    bus.en  = e;
    bus.lat = l;
    bus.tol = t;
    bus.clr = c;
    bus.x   = xv;
    bus.y   = yv;
    #1;
  endtask

  function automatic logic [7:0] pat(input int c, input int k);
    return 8'(c * k + 3);
  endfunction

  task automatic checkCleared(input string tag);
    checkOutput({tag, " armed"},    32'(bus.armed), 0);
    checkOutput({tag, " fail"},     32'(bus.fail), 0);
    checkOutput({tag, " sticky"},   32'(bus.fail_sticky), 0);
    checkOutput({tag, " err_cnt"},  32'(bus.err_cnt), 0);
    checkOutput({tag, " ff_exp"},   32'(bus.ff_exp), 0);
    checkOutput({tag, " ff_act"},   32'(bus.ff_act), 0);
    checkOutput({tag, " ff_cyc"},   32'(bus.ff_cyc), 0);
  endtask

  initial begin
    logic [7:0] xv, yv;
    logic       m;

    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    checkCleared("reset");
    checkOutput("reset mismatch", 32'(bus.mismatch), 0);

    // 1: lat=0, y follows x exactly
    rst_n = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      applyStimulus(1, 0, 0, 0, pat(c, 7), pat(c, 7));
      checkOutput($sformatf("t1 armed c%0d", c), 32'(bus.armed), 32'(c > 0));
      checkOutput($sformatf("t1 mismatch c%0d", c), 32'(bus.mismatch), 0);
      checkOutput($sformatf("t1 fail c%0d", c), 32'(bus.fail), 0);
      tick();
    end
    checkOutput("t1 err_cnt", 32'(bus.err_cnt), 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 8'h00);
    tick();
    checkOutput("t1 idle armed", 32'(bus.armed), 0);

    // 2: lat=3, counting x, y delayed by three bench flops
    for (int c = 0; c <= 50; c++) begin
      applyStimulus(1, 3, 0, 0, 8'(c), (c >= 3) ? 8'(c - 3) : 8'h00);
      checkOutput($sformatf("t2 armed c%0d", c), 32'(bus.armed), 32'(c >= 4));
      checkOutput($sformatf("t2 mismatch c%0d", c), 32'(bus.mismatch), 0);
      checkOutput($sformatf("t2 fail c%0d", c), 32'(bus.fail), 0);
      tick();
    end
    checkOutput("t2 err_cnt", 32'(bus.err_cnt), 0);
    applyStimulus(0, 3, 0, 0, 8'h00, 8'h00);
    tick();

    // 3: lat=2, tol=1, a single glitch then a double glitch
    for (int c = 0; c <= 14; c++) begin
      m  = (c == 6) || (c == 10) || (c == 11);
      yv = ((c >= 2) ? pat(c - 2, 5) : 8'h00) ^ (m ? 8'h01 : 8'h00);
      applyStimulus(1, 2, 1, 0, pat(c, 5), yv);
      checkOutput($sformatf("t3 armed c%0d", c), 32'(bus.armed), 32'(c >= 3));
      checkOutput($sformatf("t3 mismatch c%0d", c), 32'(bus.mismatch), 32'(m));
      checkOutput($sformatf("t3 fail c%0d", c), 32'(bus.fail), 32'(c == 12));
      tick();
    end
    checkOutput("t3 err_cnt", 32'(bus.err_cnt), 1);
    checkOutput("t3 sticky",  32'(bus.fail_sticky), 1);
    checkOutput("t3 ff_exp",  32'(bus.ff_exp), 32'(pat(9, 5)));
    checkOutput("t3 ff_act",  32'(bus.ff_act), 32'(pat(9, 5) ^ 8'h01));
    checkOutput("t3 ff_cyc",  32'(bus.ff_cyc), 8);
    applyStimulus(0, 2, 1, 0, 8'h00, 8'h00);
    tick();

    // 4: clear, then lat=1, tol=0, ten-cycle mismatch, one match, mismatch again
    applyStimulus(0, 1, 0, 1, 8'h00, 8'h00);
    tick();
    checkCleared("t4 clr");
    for (int c = 0; c <= 18; c++) begin
      m  = (c >= 4 && c <= 13) || c == 15 || c == 16;
      yv = ((c >= 1) ? pat(c - 1, 11) : 8'h00) ^ (m ? 8'h80 : 8'h00);
      applyStimulus(1, 1, 0, 0, pat(c, 11), yv);
      checkOutput($sformatf("t4 armed c%0d", c), 32'(bus.armed), 32'(c >= 2));
      checkOutput($sformatf("t4 mismatch c%0d", c), 32'(bus.mismatch), 32'(m));
      checkOutput($sformatf("t4 fail c%0d", c), 32'(bus.fail), 32'(c == 5 || c == 16));
      if (c == 10) checkOutput("t4 err_cnt mid", 32'(bus.err_cnt), 1);
      tick();
    end
    checkOutput("t4 err_cnt", 32'(bus.err_cnt), 2);
    checkOutput("t4 sticky",  32'(bus.fail_sticky), 1);
    checkOutput("t4 ff_exp",  32'(bus.ff_exp), 32'(pat(3, 11)));
    checkOutput("t4 ff_act",  32'(bus.ff_act), 32'(pat(3, 11) ^ 8'h80));
    checkOutput("t4 ff_cyc",  32'(bus.ff_cyc), 2);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    tick();

    // 5: lat=0, tol=2, clr lands on the failing compare
    for (int c = 0; c <= 10; c++) begin
      m  = (c >= 5 && c <= 7);
      xv = pat(c, 9);
      applyStimulus(1, 0, 2, (c == 7), xv, xv ^ (m ? 8'h0F : 8'h00));
      checkOutput($sformatf("t5 armed c%0d", c), 32'(bus.armed), 32'(c >= 1));
      checkOutput($sformatf("t5 mismatch c%0d", c), 32'(bus.mismatch), 32'(m));
      checkOutput($sformatf("t5 fail c%0d", c), 32'(bus.fail), 32'(c == 8));
      tick();
    end
    checkOutput("t5 err_cnt", 32'(bus.err_cnt), 1);
    checkOutput("t5 sticky",  32'(bus.fail_sticky), 1);
    checkOutput("t5 ff_exp",  32'(bus.ff_exp), 32'(pat(7, 9)));
    checkOutput("t5 ff_act",  32'(bus.ff_act), 32'(pat(7, 9) ^ 8'h0F));
    checkOutput("t5 ff_cyc",  32'(bus.ff_cyc), 6);
    applyStimulus(0, 0, 2, 0, 8'h00, 8'h00);
    tick();

    // 6: reset during FILL, re-enable with lat=5, then drop en while checking
    for (int c = 0; c <= 2; c++) begin
      applyStimulus(1, 5, 0, 0, pat(c, 3), pat(c, 3));
      checkOutput($sformatf("t6 fill armed c%0d", c), 32'(bus.armed), 0);
      if (c == 2) rst_n = 1'b0;
      tick();
    end
    checkCleared("t6 reset");
    checkOutput("t6 reset mismatch", 32'(bus.mismatch), 0);
    rst_n = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      applyStimulus(1, 5, 0, 0, pat(c, 3), (c >= 5) ? pat(c - 5, 3) : 8'h00);
      checkOutput($sformatf("t6 armed c%0d", c), 32'(bus.armed), 32'(c >= 6));
      checkOutput($sformatf("t6 mismatch c%0d", c), 32'(bus.mismatch), 0);
      tick();
    end
    applyStimulus(0, 5, 0, 0, 8'hAA, 8'h55);
    tick();
    checkOutput("t6 en0 armed",    32'(bus.armed), 0);
    checkOutput("t6 en0 mismatch", 32'(bus.mismatch), 0);
    checkOutput("t6 en0 fail",     32'(bus.fail), 0);
    checkOutput("t6 en0 err_cnt",  32'(bus.err_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
